frame_decimator_writer: RTL and testbench
=========================================

// Module: frame_decimator_writer
// PURPOSE
//  Consumes the RGB565 pixel stream from the camera read stage (pixel_data, pixel_valid, href, frame_done).
//  Converts each pixel to 8-bit grayscale and decimates by DECIM in both X and Y.
//  Writes the result into an external dual-port RAM as a ping-pong frame buffer (two banks).
//  Tells the downstream consumer which bank holds a complete frame.
// PARAMETERS
//  IMG_W   640  active pixels per line from the camera
//  IMG_H   480  active lines per frame
//  DECIM   4    keep every DECIM-th pixel and every DECIM-th line; power of 2, >=1
//  ADDR_W  16   RAM address width = 1 (bank bit, MSB) + clog2((IMG_W/DECIM)*(IMG_H/DECIM))
// PORTS
//  clk            in   1       pixel clock, same clock as the camera read stage
//  rst_n          in   1       synchronous, active-low reset
//  pixel_data     in   16      RGB565 {R[4:0],G[5:0],B[4:0]}, qualified by pixel_valid
//  pixel_valid    in   1       one assembled pixel this cycle
//  href           in   1       camera line-active; its falling edge = end of line
//  frame_done     in   1       1-cycle pulse at end of frame
//  rd_release     in   1       1-cycle pulse from consumer: finished reading bank rd_bank
//  wr_en          out  1       RAM write strobe
//  wr_addr        out  ADDR_W  {bank, row_ds*(IMG_W/DECIM)+col_ds}
//  wr_data        out  8       grayscale pixel
//  frame_ready    out  1       1-cycle pulse: bank rd_bank holds a complete frame
//  rd_bank        out  1       bank owned by the consumer
//  frame_dropped  out  1       1-cycle pulse: frame discarded because no bank was free
//  capturing      out  1       high while in CAPTURE
// BEHAVIOUR
//  Reset values: all outputs 0; wr_bank=0; rd_full=0; state SYNC; counters 0.
//  Reset mid-frame: pipeline writes are cancelled, state returns to SYNC, the partial frame is lost.
//  Gray conversion:
//   - Expand to 8 bits: r8={R,R[4:2]}, g8={G,G[5:4]}, b8={B,B[4:2]}.
//   - Y = (77*r8 + 150*g8 + 29*b8) >> 8, using a 16-bit accumulator with no saturation.
//   - White 0xFFFF -> 255; black -> 0.
//  Latency: wr_en fires exactly 2 cycles after a kept pixel_valid. The bank bit and address travel with the data.
//  Counters:
//   - col increments on each pixel_valid.
//   - href falling edge: col<=0, and row increments if col!=0.
//   - A pixel is kept iff col%DECIM==0, row%DECIM==0, col<IMG_W and row<IMG_H.
//   - Out-of-range pixels and lines are ignored silently.
//  FSM:
//   - SYNC: discard all pixels. On frame_done -> CAPTURE (or DROP if rd_full).
//   - CAPTURE: writes enabled into wr_bank. On frame_done:
//      - Clear counters and complete the in-flight writes.
//      - 2 cycles later (aligned with the last possible wr_en): pulse frame_ready, rd_bank<=wr_bank, rd_full<=1, wr_bank<=~wr_bank.
//      - Next state is CAPTURE if rd_full was 0 after applying release, else DROP.
//   - DROP: no writes. On frame_done: pulse frame_dropped, then -> CAPTURE if !rd_full, else stay in DROP.
//  rd_release clears rd_full.
//  Simultaneous rd_release and frame_done: the release is applied first, so the next frame captures.
//  Simultaneous pixel_valid and frame_done: the pixel belongs to the ending frame and is written if kept.
//  Short frame (fewer than IMG_H lines): still handed over as complete; the unwritten tail keeps stale data.
//  rd_release while rd_full=0: ignored.
// STRUCTURE
//  Package fdw_pkg holds:
//   - state encoding (SYNC, CAPTURE, DROP);
//   - gray coefficients 77/150/29;
//   - function rgb565_unpack;
//   - localparams OUT_W=IMG_W/DECIM, OUT_H=IMG_H/DECIM.
//  Sub-module rgb565_to_gray: 2-stage pipeline with a valid sideband plus an ADDR_W-bit tag.
//  The top level holds the counters, FSM and bank management.
// TESTING (bench params IMG_W=8, IMG_H=4, DECIM=2, ADDR_W=4)
//  1. rst_n low, then frame_done, then a 4x8 frame of 0xFFFF -> 8 writes, addr 0..7, data 255; then frame_ready with rd_bank=0.
//  2. Pixel 0xF800 (red) at col 0, row 0 -> wr_data 76 on the cycle at pixel_valid+2; 0x07E0 -> 149; 0x001F -> 28.
//  3. Two frames with no rd_release -> frame 2 written to bank 1 (addr 8..15); frame 3 gives frame_dropped and no wr_en.
//  4. rd_release on the same cycle as frame_done while rd_full=1 -> the next frame is captured, not dropped.
//  5. 10 pixels in one line (col>=IMG_W) and 6 lines -> no writes beyond col 6 or row 2; no address above 7 in bank 0.
//  6. rst_n low mid-line during CAPTURE -> wr_en=0 the next cycle; the following frame is discarded (SYNC) until frame_done.

Source files
------------

// File: rtl/fdw_pkg.sv
// Shared constants, FSM encoding and the RGB565 unpack helper for the frame
// decimator writer and its gray-conversion pipeline.
package fdw_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int DECIM_DEF = 4;
  localparam int OUT_W     = IMG_W_DEF / DECIM_DEF;
  localparam int OUT_H     = IMG_H_DEF / DECIM_DEF;

  localparam logic [1:0] ST_SYNC    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;

  // Luma weights sum to 256, so full-scale white maps exactly to 255.
  localparam logic [15:0] GRAY_R = 16'd77;
  localparam logic [15:0] GRAY_G = 16'd150;
  localparam logic [15:0] GRAY_B = 16'd29;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication keeps 0 -> 0 and full scale -> 255 for each channel.
  function automatic rgb888_t rgb565_unpack(input logic [15:0] p);
    rgb888_t c;
    c.r = {p[15:11], p[15:13]};
    c.g = {p[10:5], p[10:9]};
    c.b = {p[4:0], p[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/frame_decimator_writer_gray.sv
// Two-stage RGB565 -> 8-bit gray pipeline; valid and an opaque tag (RAM
// address incl. bank bit) travel alongside the pixel with identical latency.
module rgb565_to_gray
  import fdw_pkg::*;
#(
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_pixel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [7:0]       out_gray,
  output logic [TAG_W-1:0] out_tag
);

  rgb888_t          rgb_s1;
  logic             valid_s1;
  logic [TAG_W-1:0] tag_s1;
  logic [7:0]       gray_c;

  // 16-bit weighted sum wraps rather than saturates; the weights keep it in range.
  always_comb begin
    gray_c = 8'((GRAY_R * {8'd0, rgb_s1.r} + GRAY_G * {8'd0, rgb_s1.g} +
                 GRAY_B * {8'd0, rgb_s1.b}) >> 8);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_s1  <= 1'b0;
      rgb_s1    <= '0;
      tag_s1    <= '0;
      out_valid <= 1'b0;
      out_gray  <= '0;
      out_tag   <= '0;
    end else begin
      valid_s1  <= in_valid;
      rgb_s1    <= rgb565_unpack(in_pixel);
      tag_s1    <= in_tag;
      out_valid <= valid_s1;
      out_gray  <= gray_c;
      out_tag   <= tag_s1;
    end
  end

endmodule

// File: rtl/frame_decimator_writer.sv
// Decimates the camera pixel stream to gray and writes it into a ping-pong
// pair of RAM banks, handing complete frames to the consumer by bank index.
module frame_decimator_writer
  import fdw_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DECIM  = DECIM_DEF,
  parameter int ADDR_W = 1 + $clog2(OUT_W * OUT_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       pixel_data,
  input  logic              pixel_valid,
  input  logic              href,
  input  logic              frame_done,
  input  logic              rd_release,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_ready,
  output logic              rd_bank,
  output logic              frame_dropped,
  output logic              capturing
);

  localparam int OW = IMG_W / DECIM;
  localparam int DS = $clog2(DECIM);
  localparam int LW = ADDR_W - 1;
  localparam int CW = $clog2(IMG_W) + 2;
  localparam int RW = $clog2(IMG_H) + 2;
  localparam logic [CW-1:0] COL_LIM  = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_LIM  = RW'(IMG_H);
  localparam logic [CW-1:0] COL_MASK = CW'(DECIM - 1);
  localparam logic [RW-1:0] ROW_MASK = RW'(DECIM - 1);

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          href_d;
  logic          wr_bank;
  logic          rd_full;
  logic          handover;
  logic          href_fall;
  logic          rd_full_eff;
  logic          keep;
  logic [LW-1:0] addr_lo;

  // There is no back-pressure: a pixel is transferred on every cycle pixel_valid is high.
  always_comb begin
    href_fall   = href_d & ~href;
    rd_full_eff = rd_full & ~rd_release;
    keep        = pixel_valid && (state == ST_CAPTURE) &&
                  ((col & COL_MASK) == '0) && ((row & ROW_MASK) == '0) &&
                  (col < COL_LIM) && (row < ROW_LIM);
    addr_lo     = LW'(int'(row >> DS) * OW + int'(col >> DS));
    capturing   = (state == ST_CAPTURE);
  end

  rgb565_to_gray #(
    .TAG_W (ADDR_W)
  ) u_gray (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (keep),
    .in_pixel  (pixel_data),
    .in_tag    ({wr_bank, addr_lo}),
    .out_valid (wr_en),
    .out_gray  (wr_data),
    .out_tag   (wr_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_SYNC;
      col           <= '0;
      row           <= '0;
      href_d        <= 1'b0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      rd_full       <= 1'b0;
      handover      <= 1'b0;
      frame_ready   <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      href_d        <= href;
      handover      <= 1'b0;
      frame_ready   <= 1'b0;
      frame_dropped <= 1'b0;

      // Counters saturate so oversized lines/frames stay out of range.
      if (frame_done) begin
        col <= '0;
        row <= '0;
      end else if (href_fall) begin
        col <= '0;
        if (col != '0 && row != '1) row <= row + RW'(1);
      end else if (pixel_valid && col != '1) begin
        col <= col + CW'(1);
      end

      // Handover lands with the last in-flight write of the finished frame.
      if (handover) begin
        frame_ready <= 1'b1;
        rd_bank     <= wr_bank;
        rd_full     <= 1'b1;
        wr_bank     <= ~wr_bank;
      end else if (rd_release) begin
        rd_full <= 1'b0;
      end

      if (frame_done) begin
        case (state)
          ST_SYNC: state <= rd_full_eff ? ST_DROP : ST_CAPTURE;
          ST_CAPTURE: begin
            handover <= 1'b1;
            state    <= rd_full_eff ? ST_DROP : ST_CAPTURE;
          end
          ST_DROP: begin
            frame_dropped <= 1'b1;
            state         <= rd_full_eff ? ST_DROP : ST_CAPTURE;
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_decimator_writer.sv
// Directed bench: 8x4 frames decimated by 2 into 4-bit addressed ping-pong banks;
// every RAM write is matched against an expected {addr,data} queue.
module tb_frame_decimator_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        href;
  logic        frame_done;
  logic        rd_release;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        frame_ready;
  logic        rd_bank;
  logic        frame_dropped;
  logic        capturing;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;
  bit          mon_got;
  logic        fdp, fr, rb;

  frame_decimator_writer #(
    .IMG_W  (8),
    .IMG_H  (4),
    .DECIM  (2),
    .ADDR_W (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid),
    .href          (href),
    .frame_done    (frame_done),
    .rd_release    (rd_release),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_ready   (frame_ready),
    .rd_bank       (rd_bank),
    .frame_dropped (frame_dropped),
    .capturing     (capturing)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard: every write must be the next expected {addr, data}
  always @(negedge clk) begin
    if (wr_en) begin
      mon_got = (exp_q.size() != 0);
      mon_exp = mon_got ? exp_q.pop_front() : 12'h000;
      checks++;
      assert (mon_got && ({wr_addr, wr_data} === mon_exp)) else begin
        errors++;
        $error("FAIL write obs=%h exp=%h queued=%0d", {wr_addr, wr_data}, mon_exp, mon_got);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [15:0] d);
    pixel_valid = 1'b1;
    pixel_data  = d;
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic send_line(input int px, input logic [15:0] d, input logic [7:0] g,
                           input int r, input logic bank, input bit exp_wr);
    href = 1'b1;
    for (int c = 0; c < px; c++) begin
      if (exp_wr && (c % 2 == 0) && (c < 8) && (r % 2 == 0) && (r < 4))
        exp_q.push_back({bank, 3'((r / 2) * 4 + c / 2), g});
      pixel_valid = 1'b1;
      pixel_data  = d;
      tick();
    end
    pixel_valid = 1'b0;
    href        = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_frame(input int lines, input int px, input logic [15:0] d,
                            input logic [7:0] g, input logic bank, input bit exp_wr);
    for (int r = 0; r < lines; r++) send_line(px, d, g, r, bank, exp_wr);
  endtask

  task automatic end_frame(input logic rel, output logic o_fdp, output logic o_fr,
                           output logic o_rb);
    frame_done = 1'b1;
    rd_release = rel;
    tick();
    frame_done = 1'b0;
    rd_release = 1'b0;
    o_fdp      = frame_dropped;
    tick();
    o_fr       = frame_ready;
    o_rb       = rd_bank;
  endtask

  task automatic latency_pixel(input logic [15:0] d, input logic [3:0] a,
                               input logic [7:0] g, input string tag);
    exp_q.push_back({a, g});
    pixel_valid = 1'b1;
    pixel_data  = d;
    tick();
    pixel_valid = 1'b0;
    check({tag, "_early"}, 32'(wr_en), 32'd0);
    tick();
    check({tag, "_en"}, 32'(wr_en), 32'd1);
    check({tag, "_data"}, 32'(wr_data), 32'(g));
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    pixel_data  = '0;
    pixel_valid = 1'b0;
    href        = 1'b0;
    frame_done  = 1'b0;
    rd_release  = 1'b0;
    repeat (3) tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_frame_ready", 32'(frame_ready), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
    check("rst_frame_dropped", 32'(frame_dropped), 32'd0);
    check("rst_capturing", 32'(capturing), 32'd0);
    rst_n = 1'b1;
    tick();

    // Pixels before the first frame_done are discarded
    send_frame(4, 8, 16'hFFFF, 8'd255, 1'b0, 1'b0);
    end_frame(1'b0, fdp, fr, rb);
    check("sync_no_ready", 32'(fr), 32'd0);
    check("sync_to_capture", 32'(capturing), 32'd1);

    // Frame 1: white into bank 0
    send_frame(4, 8, 16'hFFFF, 8'd255, 1'b0, 1'b1);
    end_frame(1'b0, fdp, fr, rb);
    check("f1_ready", 32'(fr), 32'd1);
    check("f1_rd_bank", 32'(rb), 32'd0);
    check("f1_no_drop", 32'(fdp), 32'd0);
    check("f1_pending", 32'(exp_q.size()), 32'd0);
    tick();
    check("f1_ready_pulse", 32'(frame_ready), 32'd0);

    // Frame 2: primary colours with exact latency, into bank 1
    href = 1'b1;
    latency_pixel(16'hF800, 4'd8, 8'd76, "red");
    pix(16'h0000);
    latency_pixel(16'h07E0, 4'd9, 8'd149, "green");
    pix(16'h0000);
    latency_pixel(16'h001F, 4'd10, 8'd28, "blue");
    pix(16'h0000);
    exp_q.push_back({4'd11, 8'd255});
    pix(16'hFFFF);
    pix(16'h0000);
    href = 1'b0;
    tick();
    tick();
    for (int r = 1; r < 4; r++) send_line(8, 16'hFFFF, 8'd255, r, 1'b1, 1'b1);
    end_frame(1'b0, fdp, fr, rb);
    check("f2_ready", 32'(fr), 32'd1);
    check("f2_rd_bank", 32'(rb), 32'd1);
    check("f2_pending", 32'(exp_q.size()), 32'd0);
    check("f2_to_drop", 32'(capturing), 32'd0);

    // Frame 3: no bank free -> dropped, no writes
    send_frame(4, 8, 16'hFFFF, 8'd255, 1'b0, 1'b0);
    end_frame(1'b0, fdp, fr, rb);
    check("f3_dropped", 32'(fdp), 32'd1);
    check("f3_no_ready", 32'(fr), 32'd0);
    check("f3_stay_drop", 32'(capturing), 32'd0);
    check("f3_rd_bank", 32'(rb), 32'd1);

    // Frame 4: dropped, but release arrives with frame_done
    send_frame(4, 8, 16'hFFFF, 8'd255, 1'b0, 1'b0);
    end_frame(1'b1, fdp, fr, rb);
    check("f4_dropped", 32'(fdp), 32'd1);
    check("f4_release_capture", 32'(capturing), 32'd1);

    // Frame 5: oversized (10 px x 6 lines) green into bank 0
    send_frame(6, 10, 16'h07E0, 8'd149, 1'b0, 1'b1);
    end_frame(1'b0, fdp, fr, rb);
    check("f5_ready", 32'(fr), 32'd1);
    check("f5_rd_bank", 32'(rb), 32'd0);
    check("f5_no_drop", 32'(fdp), 32'd0);
    check("f5_pending", 32'(exp_q.size()), 32'd0);

    // Reset mid-line cancels the in-flight write
    href        = 1'b1;
    pixel_valid = 1'b1;
    pixel_data  = 16'hFFFF;
    tick();
    pixel_valid = 1'b0;
    href        = 1'b0;
    rst_n       = 1'b0;
    tick();
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_capturing", 32'(capturing), 32'd0);
    check("midrst_rd_bank", 32'(rd_bank), 32'd0);
    send_frame(4, 8, 16'hFFFF, 8'd255, 1'b0, 1'b0);
    end_frame(1'b0, fdp, fr, rb);
    check("midrst_sync_no_ready", 32'(fr), 32'd0);
    check("midrst_recapture", 32'(capturing), 32'd1);
    send_frame(4, 8, 16'hF800, 8'd76, 1'b0, 1'b1);
    end_frame(1'b0, fdp, fr, rb);
    check("f6_ready", 32'(fr), 32'd1);
    check("f6_rd_bank", 32'(rb), 32'd0);

    repeat (4) tick();
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
